// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment bit order, the hex glyph table and
// the helper that maps "lit" logic levels onto pin polarity.
package seven_seg_pkg;

  // Segment bit order on the seg bus is {g,f,e,d,c,b,a}.
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  // Glyphs in active-low form (bit clear = segment lit), indexed by nibble.
  localparam logic [SEG_W-1:0] HEX_SEG_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Takes a vector where 1 means "on" and returns the pin levels.
  function automatic logic [7:0] apply_pol(input logic [7:0] lit, input bit active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment decoder. Output bit set = segment lit;
// blank_i forces every segment off.
module seg7_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nibble_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_lit_o
);

  always_comb begin
    seg_lit_o = '0;
    if (!blank_i) begin
      seg_lit_o = ~HEX_SEG_AL[nibble_i];
    end
  end

endmodule

// File: rtl/scan_7seg_mux.sv
// Time-multiplexed multi-digit 7-segment driver with per-frame input snapshot,
// leading-zero suppression, PWM brightness and anti-ghosting dead time.
module scan_7seg_mux
  import seven_seg_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int TICK_LOG2        = 15,
  parameter int BRIGHT_W         = 4,
  parameter int DEAD_CYCLES      = 2,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dots,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] AN_OFF    = DIGITS'(apply_pol(8'h00, ANODE_ACTIVE_LOW));
  localparam logic [7:0]        SEGDP_OFF = apply_pol(8'h00, SEG_ACTIVE_LOW);

  logic [TICK_LOG2-1:0] prescaler_q, prescaler_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 slot_end, frame_end;

  logic [4*DIGITS-1:0]  sh_digits_q;
  logic [DIGITS-1:0]    sh_dots_q;
  logic [DIGITS-1:0]    sh_blank_q;
  logic                 sh_lz_q;
  logic [BRIGHT_W-1:0]  sh_bright_q;

  logic [DIGITS-1:0]    supp_mask;
  logic                 upper_zero;
  logic [3:0]           cur_nib;
  logic                 cur_dot, cur_blank, cur_supp;
  logic                 pwm_on, past_dead, lit;
  logic [SEG_W-1:0]     seg_lit;
  logic [DIGITS-1:0]    an_lit;

  logic [DIGITS-1:0]    an_q, an_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 frame_start_q, frame_start_d;

  assign slot_end  = &prescaler_q;
  assign frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    prescaler_d = prescaler_q + TICK_LOG2'(1);
    idx_d       = idx_q;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q <= '0;
      idx_q       <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
    end
  end

  // Shadows load on the last cycle of the final slot so each frame is tear-free;
  // blank resets to all-ones so the first frame after reset stays dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_digits_q <= '0;
      sh_dots_q   <= '0;
      sh_blank_q  <= '1;
      sh_lz_q     <= 1'b0;
      sh_bright_q <= '0;
    end else if (frame_end) begin
      sh_digits_q <= digits;
      sh_dots_q   <= dots;
      sh_blank_q  <= blank;
      sh_lz_q     <= lz_suppress;
      sh_bright_q <= brightness;
    end
  end

  always_comb begin
    supp_mask  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (sh_digits_q[4*i +: 4] == 4'h0);
      supp_mask[i] = sh_lz_q && upper_zero;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = sh_digits_q[4*i +: 4];
        cur_dot   = sh_dots_q[i];
        cur_blank = sh_blank_q[i];
        cur_supp  = supp_mask[i];
      end
    end
  end

  // Brightness compares against the prescaler's top bits, so all-zero is dark.
  assign pwm_on    = (&sh_bright_q) || (prescaler_q[TICK_LOG2-1 -: BRIGHT_W] < sh_bright_q);
  assign past_dead = prescaler_q >= TICK_LOG2'(DEAD_CYCLES);
  assign lit       = past_dead && pwm_on && !cur_blank;

  seg7_hex_decode u_decode (
    .nibble_i  (cur_nib),
    .blank_i   (cur_supp || !lit),
    .seg_lit_o (seg_lit)
  );

  always_comb begin
    an_lit = '0;
    if (lit) begin
      an_lit = DIGITS'(1) << idx_q;
    end
    an_d            = DIGITS'(apply_pol(8'(an_lit), ANODE_ACTIVE_LOW));
    {dp_d, seg_d}   = apply_pol({lit && cur_dot, seg_lit}, SEG_ACTIVE_LOW);
    frame_start_d   = (prescaler_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q          <= AN_OFF;
      seg_q         <= SEGDP_OFF[SEG_W-1:0];
      dp_q          <= SEGDP_OFF[SEG_W];
      frame_start_q <= 1'b0;
    end else begin
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_7seg_mux.sv
// Self-checking bench for scan_7seg_mux: 3 digits, 16-cycle slots, 48-cycle frames.
module tb_scan_7seg_mux;

  localparam int DIGITS      = 3;
  localparam int TICK_LOG2   = 4;
  localparam int BRIGHT_W    = 2;
  localparam int DEAD_CYCLES = 2;
  localparam int SLOT        = 16;
  localparam int FRAME       = 48;
  localparam int NVEC        = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] digits;
  logic [2:0]  dots;
  logic [2:0]  blank;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [2:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  typedef struct {
    logic [11:0]     digits;
    logic [2:0]      dots;
    logic [2:0]      blank;
    logic            lz;
    logic [1:0]      bright;
    logic [2:0][6:0] seg_lit;
  } vec_t;

  vec_t        vecs[NVEC];
  vec_t        rec_a, rec_b, rec_dark;
  logic [11:0] exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          n;

  scan_7seg_mux #(
    .DIGITS(DIGITS), .TICK_LOG2(TICK_LOG2), .BRIGHT_W(BRIGHT_W),
    .DEAD_CYCLES(DEAD_CYCLES), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .digits(digits), .dots(dots), .blank(blank),
    .lz_suppress(lz_suppress), .brightness(brightness),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [11:0] d, input logic [2:0] dt, input logic [2:0] bl,
                              input logic lz, input logic [1:0] br,
                              input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    vec_t r;
    r.digits  = d;
    r.dots    = dt;
    r.blank   = bl;
    r.lz      = lz;
    r.bright  = br;
    r.seg_lit = {s2, s1, s0};
    return r;
  endfunction

  // Expected {frame_start, an, seg, dp} at pin cycle s of a frame showing r.
  function automatic logic [11:0] exp_entry(input vec_t r, input int s);
    int         i;
    int         c;
    logic       lit;
    logic [2:0] a;
    logic [6:0] sg;
    logic       d;
    i   = s / SLOT;
    c   = s % SLOT;
    lit = (c >= DEAD_CYCLES) && (((c / 4) < int'(r.bright)) || (r.bright == 2'b11)) && !r.blank[i];
    a   = 3'b111;
    if (lit) a[i] = 1'b0;
    sg  = lit ? r.seg_lit[i] : 7'h7F;
    d   = lit ? ~r.dots[i] : 1'b1;
    return {(s == 0), a, sg, d};
  endfunction

  task automatic apply(input vec_t r);
    digits      = r.digits;
    dots        = r.dots;
    blank       = r.blank;
    lz_suppress = r.lz;
    brightness  = r.bright;
  endtask

  task automatic push_frame(input vec_t r);
    for (int s = 0; s < FRAME; s++) exp_q.push_back(exp_entry(r, s));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Advances to the next negedge where frame_start is high; n = negedges taken.
  task automatic wait_frame(output int nw);
    bit ok;
    ok = 1'b0;
    nw = 0;
    while (nw < 100 && !ok) begin
      @(negedge clk);
      nw++;
      if (frame_start === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL frame_start_timeout: got none in %0d cycles expected a pulse", nw);
    end
  endtask

  // Called on the frame_start negedge; compares the 48 pin cycles of one frame.
  task automatic check_frame(input string name, input int chg_s, input vec_t chg);
    logic [11:0] e;
    for (int s = 0; s < FRAME; s++) begin
      if (s > 0) @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL %s s=%0d: scoreboard empty got %0h expected an entry", name, s,
                 {frame_start, an, seg, dp});
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s s=%0d {fs,an,seg,dp}", name, s), {20'h0, frame_start, an, seg, dp}, {20'h0, e});
      end
      if (s == chg_s) begin
        apply(chg);
        push_frame(chg);
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(12'h1AF, 3'b000, 3'b000, 1'b0, 2'd3, 7'h79, 7'h08, 7'h0E);
    vecs[1]  = mk(12'h888, 3'b000, 3'b000, 1'b0, 2'd1, 7'h00, 7'h00, 7'h00);
    vecs[2]  = mk(12'h888, 3'b111, 3'b000, 1'b0, 2'd0, 7'h00, 7'h00, 7'h00);
    vecs[3]  = mk(12'h005, 3'b100, 3'b000, 1'b1, 2'd3, 7'h7F, 7'h7F, 7'h12);
    vecs[4]  = mk(12'h000, 3'b000, 3'b000, 1'b1, 2'd3, 7'h7F, 7'h7F, 7'h40);
    vecs[5]  = mk(12'h123, 3'b111, 3'b010, 1'b0, 2'd3, 7'h79, 7'h24, 7'h30);
    vecs[6]  = mk(12'hB6C, 3'b010, 3'b000, 1'b0, 2'd2, 7'h03, 7'h02, 7'h46);
    vecs[7]  = mk(12'h79E, 3'b001, 3'b000, 1'b1, 2'd3, 7'h78, 7'h10, 7'h06);
    vecs[8]  = mk(12'h0D0, 3'b000, 3'b000, 1'b1, 2'd3, 7'h7F, 7'h21, 7'h40);
    vecs[9]  = mk(12'h0D0, 3'b000, 3'b000, 1'b0, 2'd3, 7'h40, 7'h21, 7'h40);
    vecs[10] = mk(12'h205, 3'b000, 3'b000, 1'b1, 2'd3, 7'h24, 7'h40, 7'h12);
    vecs[11] = mk(12'h234, 3'b000, 3'b100, 1'b0, 2'd3, 7'h24, 7'h30, 7'h19);
    rec_a    = mk(12'h123, 3'b000, 3'b000, 1'b0, 2'd3, 7'h79, 7'h24, 7'h30);
    rec_b    = mk(12'h456, 3'b000, 3'b000, 1'b0, 2'd3, 7'h19, 7'h12, 7'h02);
    rec_dark = mk(12'h000, 3'b000, 3'b111, 1'b0, 2'd0, 7'h7F, 7'h7F, 7'h7F);

    // Reset state and dark first frame
    reset = 1'b1;
    apply(vecs[0]);
    @(negedge clk);
    chk("reset an", {29'h0, an}, 32'h7);
    chk("reset seg", {25'h0, seg}, 32'h7F);
    chk("reset dp", {31'h0, dp}, 32'h1);
    chk("reset frame_start", {31'h0, frame_start}, 32'h0);
    reset = 1'b0;
    push_frame(rec_dark);
    wait_frame(n);
    chk("fs latency after reset", n, 1);
    check_frame("frame1_dark", -1, rec_dark);
    push_frame(vecs[0]);
    wait_frame(n);
    chk("fs period frame2", n, 1);
    check_frame("frame2_vec0", -1, rec_dark);

    // Table-driven vectors: applied, one frame to snapshot, next frame checked
    for (int k = 1; k < NVEC; k++) begin
      apply(vecs[k]);
      push_frame(vecs[k]);
      wait_frame(n);
      wait_frame(n);
      chk($sformatf("vec%0d fs period", k), n, FRAME);
      check_frame($sformatf("vec%0d", k), -1, rec_dark);
    end

    // Mid-frame input change is held off until the next frame
    apply(rec_a);
    push_frame(rec_a);
    wait_frame(n);
    wait_frame(n);
    check_frame("snap_cur", SLOT + 5, rec_b);
    wait_frame(n);
    chk("snap fs period", n, 1);
    check_frame("snap_next", -1, rec_b);

    // Asynchronous reset at slot cycle 7 of idx1
    wait_frame(n);
    chk("pre-reset fs period", n, 1);
    for (int s = 1; s <= SLOT + 7; s++) @(negedge clk);
    chk("pre-reset an lit", {29'h0, an}, 32'h5);
    reset = 1'b1;
    #1;
    chk("async reset an", {29'h0, an}, 32'h7);
    chk("async reset seg", {25'h0, seg}, 32'h7F);
    chk("async reset dp", {31'h0, dp}, 32'h1);
    chk("async reset frame_start", {31'h0, frame_start}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_frame(rec_dark);
    wait_frame(n);
    chk("fs latency after mid reset", n, 1);
    check_frame("post_reset_dark", -1, rec_dark);
    push_frame(rec_b);
    wait_frame(n);
    chk("post_reset fs period", n, 1);
    check_frame("post_reset_show", -1, rec_dark);
    wait_frame(n);
    chk("final fs period", n, 1);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
